// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first payload, optional parity bit, one stop bit.
// Define UART_TX_PARITY_EN to build in the PARITY state and the parity logic.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  // state  | meaning
  // IDLE   | line high, waiting for Data_Valid
  // START  | start bit (0)
  // DATA   | payload bit cnt, LSB first
  // PARITY | parity bit (only with UART_TX_PARITY_EN)
  // STOP   | stop bit (1)
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  tx_n, busy_n;
  logic                  load;

`ifdef UART_TX_PARITY_EN
  logic pen_q, ptyp_q;
`else
  logic unused_par;
  assign unused_par = PAR_EN ^ PAR_TYP;
`endif

  assign load = (state == IDLE) && Data_Valid;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      data_q <= '0;
      TX_OUT <= 1'b1;
      Busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      pen_q  <= 1'b0;
      ptyp_q <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      TX_OUT <= tx_n;
      Busy   <= busy_n;
      if (load) begin
        data_q <= P_DATA;
`ifdef UART_TX_PARITY_EN
        pen_q  <= PAR_EN;
        ptyp_q <= PAR_TYP;
`endif
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE:  if (Data_Valid) state_n = START;
      START: begin
        state_n = DATA;
        cnt_n   = '0;
      end
      DATA: begin
        if (cnt == LAST) begin
`ifdef UART_TX_PARITY_EN
          state_n = pen_q ? PARITY : STOP;
`else
          state_n = STOP;
`endif
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: state_n = STOP;
`endif
      STOP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so TX_OUT/Busy are registered yet change on the entering edge.
  always_comb begin
    tx_n   = 1'b1;
    busy_n = (state_n != IDLE);
    case (state_n)
      START:  tx_n = 1'b0;
      DATA:   tx_n = data_q[cnt_n];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_n = (^data_q) ^ ptyp_q;
`endif
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer; expected {Busy,TX_OUT} per cycle is queued at stimulus time.
module tb_uart_tx_serializer;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic         Data_Valid;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic         TX_OUT;
  logic         Busy;

  logic [1:0]   sb[$];
  int           total = 0;
  int           bad = 0;
  string        step;

  uart_tx_serializer #(.DATA_WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%b expected=%b", step, tag, obs, exp);
    end
  endtask

  function automatic void push_frame(input logic [W-1:0] d, input logic pe, input logic pt);
    sb.push_back(2'b10);
    for (int i = 0; i < W; i++) sb.push_back({1'b1, d[i]});
`ifdef UART_TX_PARITY_EN
    if (pe) sb.push_back({1'b1, (^d) ^ pt});
`else
    if (pe && pt && 1'b0) sb.push_back(2'b11);
`endif
    sb.push_back(2'b11);
  endfunction

  function automatic void push_idle(input int n);
    for (int i = 0; i < n; i++) sb.push_back(2'b01);
  endfunction

  task automatic drain_n(input int n);
    logic [1:0] e;
    for (int i = 0; i < n; i++) begin
      cyc();
      e = sb.pop_front();
      chk("tx", TX_OUT, e[0]);
      chk("busy", Busy, e[1]);
    end
  endtask

  task automatic drain();
    drain_n(sb.size());
  endtask

  // One-cycle request, then scramble inputs to prove the frame uses the captured values.
  task automatic frame(input logic [W-1:0] d, input logic pe, input logic pt);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
    push_frame(d, pe, pt);
    push_idle(1);
    drain_n(1);
    Data_Valid = 1'b0;
    P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt;
    drain();
  endtask

  initial begin
    RST = 1'b1; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    step = "reset";
    cyc(); cyc();
    chk("tx", TX_OUT, 1'b1);
    chk("busy", Busy, 1'b0);

    step = "rst_prio";
    Data_Valid = 1'b1; P_DATA = 8'hC3;
    cyc();
    chk("tx", TX_OUT, 1'b1);
    chk("busy", Busy, 1'b0);
    Data_Valid = 1'b0; RST = 1'b0;
    push_idle(2);
    drain();

    step = "a5_nopar";
    frame(8'hA5, 1'b0, 1'b0);

`ifdef UART_TX_PARITY_EN
    step = "a5_even";
    frame(8'hA5, 1'b1, 1'b0);
    step = "a5_odd";
    frame(8'hA5, 1'b1, 1'b1);
    step = "01_odd";
    frame(8'h01, 1'b1, 1'b1);
`endif

    step = "parEn_cfg";
    frame(8'h5A, 1'b1, 1'b1);

    step = "busy_req";
    P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    push_frame(8'hA5, 1'b0, 1'b0);
    push_idle(4);
    drain_n(1);
    Data_Valid = 1'b0;
    drain_n(2);
    Data_Valid = 1'b1; P_DATA = 8'h3C;
    drain_n(1);
    Data_Valid = 1'b0;
    drain();

    step = "rst_mid";
    P_DATA = 8'h77; Data_Valid = 1'b1;
    push_frame(8'h77, 1'b0, 1'b0);
    drain_n(1);
    Data_Valid = 1'b0;
    drain_n(3);
    sb.delete();
    RST = 1'b1;
    cyc();
    chk("tx", TX_OUT, 1'b1);
    chk("busy", Busy, 1'b0);
    RST = 1'b0;
    push_idle(2);
    drain();
    step = "after_rst";
    frame(8'h55, 1'b0, 1'b0);

    step = "hold";
    P_DATA = 8'hFF; PAR_EN = 1'b0; Data_Valid = 1'b1;
    push_frame(8'hFF, 1'b0, 1'b0);
    push_idle(1);
    push_frame(8'h00, 1'b0, 1'b0);
    push_idle(2);
    drain_n(1);
    P_DATA = 8'h00;
    drain_n(W + 2);
    drain_n(1);
    Data_Valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
